// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// mux selects, opcode/funct values and ALU operation codes.
package mc_ctrl_pkg;

   // FSM states; FETCH is zero so the reset value of `state` reads as FETCH
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_t;

   // PC source select
   localparam logic [1:0] PC_MUX_SEL_PC4    = 2'b00;
   localparam logic [1:0] PC_MUX_SEL_BRANCH = 2'b01;
   localparam logic [1:0] PC_MUX_SEL_JUMP   = 2'b10;
   localparam logic [1:0] PC_MUX_SEL_RS     = 2'b11;

   // register file destination select
   localparam logic [1:0] REG_MUX_SEL_RT = 2'b00;
   localparam logic [1:0] REG_MUX_SEL_RD = 2'b01;
   localparam logic [1:0] REG_MUX_SEL_RA = 2'b10;

   // register file write data select
   localparam logic [1:0] DR_MUX_SEL_ALU = 2'b00;
   localparam logic [1:0] DR_MUX_SEL_MDR = 2'b01;
   localparam logic [1:0] DR_MUX_SEL_PC  = 2'b10;

   // opcodes
   localparam logic [5:0] INSTR_RTYPE_OP = 6'b000000;
   localparam logic [5:0] INSTR_J_OP     = 6'b000010;
   localparam logic [5:0] INSTR_JAL_OP   = 6'b000011;
   localparam logic [5:0] INSTR_BEQ_OP   = 6'b000100;
   localparam logic [5:0] INSTR_BNE_OP   = 6'b000101;
   localparam logic [5:0] INSTR_SLTI_OP  = 6'b001010;
   localparam logic [5:0] INSTR_ANDI_OP  = 6'b001100;
   localparam logic [5:0] INSTR_ORI_OP   = 6'b001101;
   localparam logic [5:0] INSTR_LUI_OP   = 6'b001111;
   localparam logic [5:0] INSTR_LW_OP    = 6'b100011;
   localparam logic [5:0] INSTR_SW_OP    = 6'b101011;

   // R-type funct codes
   localparam logic [5:0] INSTR_SLL_FUNCT  = 6'b000000;
   localparam logic [5:0] INSTR_SRL_FUNCT  = 6'b000010;
   localparam logic [5:0] INSTR_SRA_FUNCT  = 6'b000011;
   localparam logic [5:0] INSTR_JR_FUNCT   = 6'b001000;
   localparam logic [5:0] INSTR_ADD_FUNCT  = 6'b100000;
   localparam logic [5:0] INSTR_ADDU_FUNCT = 6'b100001;
   localparam logic [5:0] INSTR_SUB_FUNCT  = 6'b100010;
   localparam logic [5:0] INSTR_SUBU_FUNCT = 6'b100011;
   localparam logic [5:0] INSTR_AND_FUNCT  = 6'b100100;
   localparam logic [5:0] INSTR_OR_FUNCT   = 6'b100101;
   localparam logic [5:0] INSTR_SLT_FUNCT  = 6'b101010;

   // ALU operation codes
   localparam logic [4:0] ALUOp_nop  = 5'd0;
   localparam logic [4:0] ALUOp_lui  = 5'd1;
   localparam logic [4:0] ALUOp_add  = 5'd2;
   localparam logic [4:0] ALUOp_sub  = 5'd3;
   localparam logic [4:0] ALUOp_addu = 5'd4;
   localparam logic [4:0] ALUOp_subu = 5'd5;
   localparam logic [4:0] ALUOp_and  = 5'd6;
   localparam logic [4:0] ALUOp_or   = 5'd7;
   localparam logic [4:0] ALUOp_slt  = 5'd8;
   localparam logic [4:0] ALUOp_sll  = 5'd9;
   localparam logic [4:0] ALUOp_srl  = 5'd10;
   localparam logic [4:0] ALUOp_sra  = 5'd11;

endpackage

// File: rtl/mc_ctrl_alu_decode.sv
// Combinational opcode/funct decode: ALU operation, operand selects,
// immediate extension and whether the instruction is supported at all.
module alu_decode
   import mc_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 5
) (
   input  logic [5:0]         opcode,
   input  logic [5:0]         func,
   output logic [ALUOP_W-1:0] aluctrl,
   output logic               alusrc,
   output logic               alusrc2,
   output logic               extop,
   output logic               legal
);

   logic [4:0] op;

   // per-instruction ALU mapping; anything unlisted is flagged illegal
   always_comb begin
      op      = ALUOp_nop;
      alusrc  = 1'b0;
      alusrc2 = 1'b0;
      extop   = 1'b0;
      legal   = 1'b1;
      case (opcode)
         INSTR_RTYPE_OP: begin
            case (func)
               INSTR_ADD_FUNCT:  op = ALUOp_add;
               INSTR_ADDU_FUNCT: op = ALUOp_addu;
               INSTR_SUB_FUNCT:  op = ALUOp_sub;
               INSTR_SUBU_FUNCT: op = ALUOp_subu;
               INSTR_AND_FUNCT:  op = ALUOp_and;
               INSTR_OR_FUNCT:   op = ALUOp_or;
               INSTR_SLT_FUNCT:  op = ALUOp_slt;
               // shifts take their source from rt on operand A
               INSTR_SLL_FUNCT:  begin op = ALUOp_sll; alusrc2 = 1'b1; end
               INSTR_SRL_FUNCT:  begin op = ALUOp_srl; alusrc2 = 1'b1; end
               INSTR_SRA_FUNCT:  begin op = ALUOp_sra; alusrc2 = 1'b1; end
               INSTR_JR_FUNCT:   op = ALUOp_nop;
               default:          legal = 1'b0;
            endcase
         end
         INSTR_ORI_OP:  begin op = ALUOp_or;  alusrc = 1'b1; end
         INSTR_ANDI_OP: begin op = ALUOp_and; alusrc = 1'b1; end
         INSTR_LUI_OP:  begin op = ALUOp_lui; alusrc = 1'b1; end
         INSTR_SLTI_OP: begin op = ALUOp_slt; alusrc = 1'b1; extop = 1'b1; end
         INSTR_LW_OP,
         INSTR_SW_OP:   begin op = ALUOp_add; alusrc = 1'b1; extop = 1'b1; end
         INSTR_BEQ_OP,
         INSTR_BNE_OP:  begin op = ALUOp_sub; extop = 1'b1; end
         INSTR_J_OP,
         INSTR_JAL_OP:  op = ALUOp_nop;
         default:       legal = 1'b0;
      endcase
   end

   assign aluctrl = ALUOP_W'(op);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with a
// memory-ready stall handshake and a retired-instruction counter.
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int ALUOP_W     = 5,
   parameter bit USE_MEM_RDY = 1'b1,
   parameter int CNT_W       = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic [5:0]         func,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic [1:0]         PC_sel,
   output logic               IRWrite,
   output logic               MemReq,
   output logic               MemWrite,
   output logic               IorD,
   output logic               RegWrite,
   output logic [1:0]         RegDst,
   output logic [1:0]         DatatoReg,
   output logic               ALUSrc,
   output logic               ALUSrc2,
   output logic               ExtOp,
   output logic [ALUOP_W-1:0] ALUCtrl,
   output logic               illegal,
   output logic [2:0]         state,
   output logic [CNT_W-1:0]   instret
);

   state_t             cur_st, nxt_st;
   logic               rdy, legal, retire;
   logic [ALUOP_W-1:0] dec_alu;
   logic               dec_src, dec_src2, dec_ext;
   logic               is_r, is_j, is_jal, is_jr, is_beq, is_bne, is_lw, is_sw;

   alu_decode #(.ALUOP_W(ALUOP_W)) u_alu_decode (
      .opcode  (opcode),
      .func    (func),
      .aluctrl (dec_alu),
      .alusrc  (dec_src),
      .alusrc2 (dec_src2),
      .extop   (dec_ext),
      .legal   (legal)
   );

   assign rdy    = USE_MEM_RDY ? mem_ready : 1'b1;
   assign is_r   = (opcode == INSTR_RTYPE_OP);
   assign is_j   = (opcode == INSTR_J_OP);
   assign is_jal = (opcode == INSTR_JAL_OP);
   assign is_jr  = is_r && (func == INSTR_JR_FUNCT);
   assign is_beq = (opcode == INSTR_BEQ_OP);
   assign is_bne = (opcode == INSTR_BNE_OP);
   assign is_lw  = (opcode == INSTR_LW_OP);
   assign is_sw  = (opcode == INSTR_SW_OP);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cur_st <= ST_FETCH;
      else     cur_st <= nxt_st;
   end

   // retired-instruction counter, wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         instret <= '0;
      else if (retire) instret <= instret + CNT_W'(1);
   end

   // next state and outputs; reset masks everything so a pending request
   // drops asynchronously rather than at the next edge
   always_comb begin
      nxt_st    = cur_st;
      retire    = 1'b0;
      PCWrite   = 1'b0;
      PC_sel    = PC_MUX_SEL_PC4;
      IRWrite   = 1'b0;
      MemReq    = 1'b0;
      MemWrite  = 1'b0;
      IorD      = 1'b0;
      RegWrite  = 1'b0;
      RegDst    = REG_MUX_SEL_RT;
      DatatoReg = DR_MUX_SEL_ALU;
      ALUSrc    = 1'b0;
      ALUSrc2   = 1'b0;
      ExtOp     = 1'b0;
      ALUCtrl   = '0;
      illegal   = 1'b0;
      state     = ST_FETCH;
      if (!rst) begin
         state = cur_st;
         case (cur_st)
            ST_FETCH: begin
               MemReq = 1'b1;
               if (rdy) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
                  nxt_st  = ST_DECODE;
               end
            end
            ST_DECODE: begin
               nxt_st = ST_FETCH;
               if (!legal) begin
                  illegal = 1'b1;
               end else if (is_j || is_jal) begin
                  PCWrite = 1'b1;
                  PC_sel  = PC_MUX_SEL_JUMP;
                  retire  = 1'b1;
                  if (is_jal) begin
                     // PC already advanced in FETCH, so $31 gets PC+4
                     RegWrite  = 1'b1;
                     RegDst    = REG_MUX_SEL_RA;
                     DatatoReg = DR_MUX_SEL_PC;
                  end
               end else if (is_jr) begin
                  PCWrite = 1'b1;
                  PC_sel  = PC_MUX_SEL_RS;
                  retire  = 1'b1;
               end else begin
                  nxt_st = ST_EXEC;
               end
            end
            ST_EXEC: begin
               ALUCtrl = dec_alu;
               ALUSrc  = dec_src;
               ALUSrc2 = dec_src2;
               ExtOp   = dec_ext;
               if (is_beq || is_bne) begin
                  PCWrite = is_beq ? zero : ~zero;
                  PC_sel  = PC_MUX_SEL_BRANCH;
                  retire  = 1'b1;
                  nxt_st  = ST_FETCH;
               end else if (is_lw || is_sw) begin
                  nxt_st = ST_MEM;
               end else begin
                  nxt_st = ST_WB;
               end
            end
            ST_MEM: begin
               MemReq   = 1'b1;
               IorD     = 1'b1;
               MemWrite = is_sw;
               if (rdy) begin
                  nxt_st = is_sw ? ST_FETCH : ST_WB;
                  retire = is_sw;
               end
            end
            ST_WB: begin
               // I-type ALU ops (andi included) write rt; only R-type writes rd
               RegWrite  = 1'b1;
               RegDst    = is_r ? REG_MUX_SEL_RD : REG_MUX_SEL_RT;
               DatatoReg = is_lw ? DR_MUX_SEL_MDR : DR_MUX_SEL_ALU;
               retire    = 1'b1;
               nxt_st    = ST_FETCH;
            end
            default: nxt_st = ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: each driven cycle pushes its expected
// output snapshot; a negedge monitor pops and compares.
module tb_mc_ctrl;
   import mc_ctrl_pkg::*;

   typedef struct packed {
      logic [2:0] st;
      logic       pcw;
      logic [1:0] pcsel;
      logic       irw, mreq, mwr, iord, rw;
      logic [1:0] rdst, d2r;
      logic       asrc, asrc2, ext;
      logic [4:0] aop;
      logic       ill;
   } ov_t;

   typedef struct {
      string       tag;
      ov_t         o;
      logic [31:0] cnt;
   } sb_t;

   logic        clk = 1'b0, rst = 1'b1;
   logic [5:0]  opcode = '0, func = '0;
   logic        zero = 1'b0, mem_ready = 1'b0;
   logic        PCWrite, IRWrite, MemReq, MemWrite, IorD, RegWrite;
   logic        ALUSrc, ALUSrc2, ExtOp, illegal;
   logic [1:0]  PC_sel, RegDst, DatatoReg;
   logic [4:0]  ALUCtrl;
   logic [2:0]  state;
   logic [31:0] instret;
   ov_t         dut_o;

   int          checks = 0, errors = 0;
   logic [31:0] exp_cnt = '0;
   sb_t         sb[$];

   mc_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .PC_sel(PC_sel),
      .IRWrite(IRWrite), .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD),
      .RegWrite(RegWrite), .RegDst(RegDst), .DatatoReg(DatatoReg),
      .ALUSrc(ALUSrc), .ALUSrc2(ALUSrc2), .ExtOp(ExtOp), .ALUCtrl(ALUCtrl),
      .illegal(illegal), .state(state), .instret(instret)
   );

   assign dut_o = {state, PCWrite, PC_sel, IRWrite, MemReq, MemWrite, IorD,
                   RegWrite, RegDst, DatatoReg, ALUSrc, ALUSrc2, ExtOp,
                   ALUCtrl, illegal};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // monitor: one scoreboard entry per driven cycle
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         sb_t e;
         e = sb.pop_front();
         chk({e.tag, ".outs"}, 64'(dut_o), 64'(e.o));
         chk({e.tag, ".instret"}, 64'(instret), 64'(e.cnt));
      end
   end

   // expected ALU-side decode for an instruction, written from the ISA table
   function automatic void exp_dec(input logic [5:0] op, input logic [5:0] fn,
                                   output logic [4:0] a, output logic s,
                                   output logic s2, output logic e, output logic lg);
      a = ALUOp_nop; s = 0; s2 = 0; e = 0; lg = 1;
      case (op)
         6'h00: case (fn)
            6'h20: a = ALUOp_add;
            6'h21: a = ALUOp_addu;
            6'h22: a = ALUOp_sub;
            6'h23: a = ALUOp_subu;
            6'h24: a = ALUOp_and;
            6'h25: a = ALUOp_or;
            6'h2a: a = ALUOp_slt;
            6'h00: begin a = ALUOp_sll; s2 = 1; end
            6'h02: begin a = ALUOp_srl; s2 = 1; end
            6'h03: begin a = ALUOp_sra; s2 = 1; end
            6'h08: ;
            default: lg = 0;
         endcase
         6'h0d: begin a = ALUOp_or;  s = 1; end
         6'h0c: begin a = ALUOp_and; s = 1; end
         6'h0f: begin a = ALUOp_lui; s = 1; end
         6'h0a: begin a = ALUOp_slt; s = 1; e = 1; end
         6'h23, 6'h2b: begin a = ALUOp_add; s = 1; e = 1; end
         6'h04, 6'h05: begin a = ALUOp_sub; e = 1; end
         6'h02, 6'h03: ;
         default: lg = 0;
      endcase
   endfunction

   // drive one cycle and queue its expected outputs
   task automatic cyc(input string tag, input logic rdy, input ov_t o);
      mem_ready = rdy;
      sb.push_back('{tag, o, exp_cnt});
      @(posedge clk); #1;
   endtask

   // run one instruction from FETCH, with wait cycles in FETCH and MEM
   task automatic instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input int fw, input int mw);
      ov_t o;
      logic [4:0] a;
      logic s, s2, e, lg;
      exp_dec(op, fn, a, s, s2, e, lg);
      opcode = op; func = fn; zero = z;
      for (int i = 0; i < fw; i++) begin
         o = '0; o.st = 3'd0; o.mreq = 1; cyc({nm, ".Fw"}, 1'b0, o);
      end
      o = '0; o.st = 3'd0; o.mreq = 1; o.irw = 1; o.pcw = 1;
      cyc({nm, ".F"}, 1'b1, o);
      o = '0; o.st = 3'd1;
      if (!lg) begin
         o.ill = 1; cyc({nm, ".D"}, 1'b1, o); return;
      end
      if (op == 6'h02 || op == 6'h03) begin
         o.pcw = 1; o.pcsel = 2'b10;
         if (op == 6'h03) begin o.rw = 1; o.rdst = 2'b10; o.d2r = 2'b10; end
         cyc({nm, ".D"}, 1'b1, o); exp_cnt++; return;
      end
      if (op == 6'h00 && fn == 6'h08) begin
         o.pcw = 1; o.pcsel = 2'b11;
         cyc({nm, ".D"}, 1'b1, o); exp_cnt++; return;
      end
      cyc({nm, ".D"}, 1'b1, o);
      o = '0; o.st = 3'd2; o.aop = a; o.asrc = s; o.asrc2 = s2; o.ext = e;
      if (op == 6'h04 || op == 6'h05) begin
         o.pcsel = 2'b01; o.pcw = (op == 6'h04) ? z : !z;
         cyc({nm, ".E"}, 1'b1, o); exp_cnt++; return;
      end
      cyc({nm, ".E"}, 1'b1, o);
      if (op == 6'h23 || op == 6'h2b) begin
         o = '0; o.st = 3'd3; o.mreq = 1; o.iord = 1; o.mwr = (op == 6'h2b);
         for (int i = 0; i < mw; i++) cyc({nm, ".Mw"}, 1'b0, o);
         cyc({nm, ".M"}, 1'b1, o);
         if (op == 6'h2b) begin exp_cnt++; return; end
      end
      o = '0; o.st = 3'd4; o.rw = 1;
      o.rdst = (op == 6'h00) ? 2'b01 : 2'b00;
      o.d2r  = (op == 6'h23) ? 2'b01 : 2'b00;
      cyc({nm, ".W"}, 1'b1, o); exp_cnt++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      ov_t o;
      // reset: FETCH state but every output masked
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.outs", 64'(dut_o), 64'd0);
      chk("rst.instret", 64'(instret), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      instr("addu",   6'h00, 6'h21, 0, 0, 0);
      instr("lw",     6'h23, 6'h00, 0, 0, 3);
      instr("beq1",   6'h04, 6'h00, 1, 0, 0);
      instr("beq0",   6'h04, 6'h00, 0, 0, 0);
      instr("bne1",   6'h05, 6'h00, 1, 0, 0);
      instr("bne0",   6'h05, 6'h00, 0, 0, 0);
      instr("jal",    6'h03, 6'h00, 0, 0, 0);
      instr("jr",     6'h00, 6'h08, 0, 0, 0);
      instr("j",      6'h02, 6'h00, 0, 0, 0);
      instr("ill_op", 6'h3f, 6'h00, 0, 0, 0);
      instr("ill_fn", 6'h00, 6'h3f, 0, 0, 0);
      instr("andi",   6'h0c, 6'h00, 0, 0, 0);
      instr("ori",    6'h0d, 6'h00, 0, 1, 0);
      instr("slti",   6'h0a, 6'h00, 0, 0, 0);
      instr("lui",    6'h0f, 6'h00, 0, 0, 0);
      instr("sll",    6'h00, 6'h00, 0, 0, 0);
      instr("sra",    6'h00, 6'h03, 0, 0, 0);
      instr("sub",    6'h00, 6'h22, 0, 2, 0);
      instr("sw",     6'h2b, 6'h00, 0, 0, 1);
      instr("lw0",    6'h23, 6'h00, 0, 0, 0);

      // reset during a stalled sw in MEM
      opcode = 6'h2b; func = 6'h00;
      o = '0; o.st = 3'd0; o.mreq = 1; o.irw = 1; o.pcw = 1; cyc("rsw.F", 1'b1, o);
      o = '0; o.st = 3'd1; cyc("rsw.D", 1'b1, o);
      o = '0; o.st = 3'd2; o.aop = ALUOp_add; o.asrc = 1; o.ext = 1; cyc("rsw.E", 1'b1, o);
      mem_ready = 1'b0;
      o = '0; o.st = 3'd3; o.mreq = 1; o.iord = 1; o.mwr = 1;
      sb.push_back('{"rsw.Mw", o, exp_cnt});
      @(negedge clk); #2;
      rst = 1'b1; #1;
      chk("rsw.memreq", 64'(MemReq), 64'd0);
      chk("rsw.memwrite", 64'(MemWrite), 64'd0);
      chk("rsw.instret", 64'(instret), 64'd0);
      chk("rsw.state", 64'(state), 64'd0);
      @(negedge clk);
      chk("rsw.held", 64'(dut_o), 64'd0);
      rst = 1'b0;
      exp_cnt = '0;
      @(posedge clk); #1;
      instr("post_rst", 6'h00, 6'h21, 0, 0, 0);

      @(negedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
